// File: rtl/parking_occupancy_counter_if.sv
// Signal bundle between the parking occupancy counter and its environment.
// The master modport drives the raw sensors and clr_err; the slave modport is the counter.
interface parking_occupancy_counter_if;
  logic       raw_entrance;
  logic       raw_exit;
  logic       raw_leave;
  logic       clr_err;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic [6:0] occupancy;
  logic [6:0] free_spaces;
  logic       full;
  logic       empty;
  logic       ovf_err;
  logic       unf_err;
  logic [6:0] HEX_3;
  logic [6:0] HEX_4;

  modport master (
    output raw_entrance, raw_exit, raw_leave, clr_err,
    input  sensor_entrance, sensor_exit, occupancy, free_spaces,
    input  full, empty, ovf_err, unf_err, HEX_3, HEX_4
  );

  modport slave (
    input  raw_entrance, raw_exit, raw_leave, clr_err,
    output sensor_entrance, sensor_exit, occupancy, free_spaces,
    output full, empty, ovf_err, unf_err, HEX_3, HEX_4
  );
endinterface

// File: rtl/parking_occupancy_counter.sv
// Beam-sensor conditioning and lot occupancy tracking for the parking gate controller.
// Define PARKING_FREE_HEX_EN to build the two-digit free-space seven-segment display.
module parking_occupancy_counter #(
  parameter int CAPACITY        = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  parking_occupancy_counter_if.slave  bus
);
  localparam logic [6:0] CAP7    = 7'(CAPACITY);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 = entrance, 1 = exit (enter events), 2 = leave.
  logic raw    [3];
  logic deb_q  [3];
  logic deb_d  [3];

  assign raw[0] = bus.raw_entrance;
  assign raw[1] = bus.raw_exit;
  assign raw[2] = bus.raw_leave;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic       sync1_q;
      logic       sync2_q;
      logic       lvl_q;
      logic       lvl_d;
      logic [7:0] cnt_q;
      logic [7:0] cnt_d;

      always_comb begin
        lvl_d = lvl_q;
        cnt_d = '0;
        if (sync2_q != lvl_q) begin
          if (cnt_q == DB_LAST) begin
            lvl_d = ~lvl_q;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          lvl_q   <= 1'b0;
          cnt_q   <= '0;
        end else begin
          sync1_q <= raw[gi];
          sync2_q <= sync1_q;
          lvl_q   <= lvl_d;
          cnt_q   <= cnt_d;
        end
      end

      assign deb_q[gi] = lvl_q;
      assign deb_d[gi] = lvl_d;
    end
  endgenerate

  logic       exit_prev_q;
  logic       leave_prev_q;
  logic       enter_ev;
  logic       leave_ev;
  logic [6:0] occ_q;
  logic [6:0] occ_d;
  logic       ovf_q;
  logic       ovf_d;
  logic       unf_q;
  logic       unf_d;
  logic       full_q;
  logic       empty_q;
  logic [6:0] free_q;
  logic       sens_ent_q;

  assign enter_ev = deb_q[1] & ~exit_prev_q;
  assign leave_ev = deb_q[2] & ~leave_prev_q;

  // A fresh error in the same cycle as clr_err must win, so it is applied last.
  always_comb begin
    occ_d = occ_q;
    ovf_d = bus.clr_err ? 1'b0 : ovf_q;
    unf_d = bus.clr_err ? 1'b0 : unf_q;
    if (enter_ev && !leave_ev) begin
      if (occ_q == CAP7) begin
        ovf_d = 1'b1;
      end else begin
        occ_d = occ_q + 7'd1;
      end
    end else if (leave_ev && !enter_ev) begin
      if (occ_q == 7'd0) begin
        unf_d = 1'b1;
      end else begin
        occ_d = occ_q - 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exit_prev_q  <= 1'b0;
      leave_prev_q <= 1'b0;
      occ_q        <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      full_q       <= (CAP7 == 7'd0);
      empty_q      <= 1'b1;
      free_q       <= CAP7;
      sens_ent_q   <= 1'b0;
    end else begin
      exit_prev_q  <= deb_q[1];
      leave_prev_q <= deb_q[2];
      occ_q        <= occ_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      full_q       <= (occ_d == CAP7);
      empty_q      <= (occ_d == 7'd0);
      free_q       <= CAP7 - occ_d;
      sens_ent_q   <= deb_d[0] & (occ_d != CAP7);
    end
  end

  assign bus.sensor_entrance = sens_ent_q;
  assign bus.sensor_exit     = deb_q[1];
  assign bus.occupancy       = occ_q;
  assign bus.free_spaces     = free_q;
  assign bus.full            = full_q;
  assign bus.empty           = empty_q;
  assign bus.ovf_err         = ovf_q;
  assign bus.unf_err         = unf_q;

`ifdef PARKING_FREE_HEX_EN
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [3:0] tens;
  logic [3:0] ones;
  logic [6:0] hex3_q;
  logic [6:0] hex4_q;

  assign tens = 4'(free_q / 7'd10);
  assign ones = 4'(free_q % 7'd10);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex3_q <= '0;
      hex4_q <= '0;
    end else if (full_q) begin
      hex3_q <= 7'b1001111;
      hex4_q <= 7'b1001111;
    end else begin
      hex3_q <= (tens == 4'd0) ? 7'b0000000 : seg7(tens);
      hex4_q <= seg7(ones);
    end
  end

  assign bus.HEX_3 = hex3_q;
  assign bus.HEX_4 = hex4_q;
`else
  assign bus.HEX_3 = 7'b0000000;
  assign bus.HEX_4 = 7'b0000000;
`endif

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed, table-driven bench for parking_occupancy_counter (CAPACITY=16, DEBOUNCE_CYCLES=4).
module tb_parking_occupancy_counter;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  parking_occupancy_counter_if bus_if ();

  parking_occupancy_counter #(
    .CAPACITY        (16),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic clr;
    logic ex;
    logic lv;
    int   occ;
    logic ovf;
    logic unf;
  } vec_t;

  vec_t vecs [32];

`ifdef PARKING_FREE_HEX_EN
  localparam logic [6:0] EXP_HEX_FULL3 = 7'b1001111;
  localparam logic [6:0] EXP_HEX_FULL4 = 7'b1001111;
  localparam logic [6:0] EXP_HEX9_3    = 7'b0000000;
  localparam logic [6:0] EXP_HEX9_4    = 7'b1111011;
`else
  localparam logic [6:0] EXP_HEX_FULL3 = 7'b0000000;
  localparam logic [6:0] EXP_HEX_FULL4 = 7'b0000000;
  localparam logic [6:0] EXP_HEX9_3    = 7'b0000000;
  localparam logic [6:0] EXP_HEX9_4    = 7'b0000000;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic clr, input logic ex, input logic lv,
                         input int occ, input logic ovf, input logic unf);
    vecs[i].clr = clr;
    vecs[i].ex  = ex;
    vecs[i].lv  = lv;
    vecs[i].occ = occ;
    vecs[i].ovf = ovf;
    vecs[i].unf = unf;
  endtask

  task automatic apply_vec(input int i);
    if (vecs[i].clr) begin
      bus_if.clr_err = 1'b1;
      tick();
      bus_if.clr_err = 1'b0;
    end
    bus_if.raw_exit  = vecs[i].ex;
    bus_if.raw_leave = vecs[i].lv;
    repeat (10) tick();
    bus_if.raw_exit  = 1'b0;
    bus_if.raw_leave = 1'b0;
    repeat (10) tick();
    chk($sformatf("v%0d_occupancy", i), int'(bus_if.occupancy), vecs[i].occ);
    chk($sformatf("v%0d_free", i), int'(bus_if.free_spaces), 16 - vecs[i].occ);
    chk($sformatf("v%0d_full", i), int'(bus_if.full), (vecs[i].occ == 16) ? 1 : 0);
    chk($sformatf("v%0d_empty", i), int'(bus_if.empty), (vecs[i].occ == 0) ? 1 : 0);
    chk($sformatf("v%0d_ovf", i), int'(bus_if.ovf_err), int'(vecs[i].ovf));
    chk($sformatf("v%0d_unf", i), int'(bus_if.unf_err), int'(vecs[i].unf));
    $display("vec %0d: ex=%0b lv=%0b clr=%0b -> occ=%0d ovf=%0b unf=%0b", i, vecs[i].ex,
             vecs[i].lv, vecs[i].clr, bus_if.occupancy, bus_if.ovf_err, bus_if.unf_err);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_occupancy"}, int'(bus_if.occupancy), 0);
    chk({tag, "_free"}, int'(bus_if.free_spaces), 16);
    chk({tag, "_full"}, int'(bus_if.full), 0);
    chk({tag, "_empty"}, int'(bus_if.empty), 1);
    chk({tag, "_sens_ent"}, int'(bus_if.sensor_entrance), 0);
    chk({tag, "_sens_exit"}, int'(bus_if.sensor_exit), 0);
    chk({tag, "_ovf"}, int'(bus_if.ovf_err), 0);
    chk({tag, "_unf"}, int'(bus_if.unf_err), 0);
    chk({tag, "_hex3"}, int'(bus_if.HEX_3), 0);
    chk({tag, "_hex4"}, int'(bus_if.HEX_4), 0);
  endtask

  initial begin
    logic found;
    logic prev_se;
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bus_if.raw_entrance = 1'b0;
    bus_if.raw_exit     = 1'b0;
    bus_if.raw_leave    = 1'b0;
    bus_if.clr_err      = 1'b0;

    // Vector table: expected occupancy and sticky flags after each pulse.
    set_vec(0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    set_vec(1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) set_vec(1 + k, 1'b0, 1'b1, 1'b0, k, 1'b0, 1'b0);
    set_vec(18, 1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) set_vec(19 + k, 1'b0, 1'b0, 1'b1, 14 - k, 1'b1, 1'b0);
    set_vec(29, 1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0);
    set_vec(30, 1'b0, 1'b1, 1'b0, 6, 1'b0, 1'b0);
    set_vec(31, 1'b0, 1'b1, 1'b0, 7, 1'b0, 1'b0);

    repeat (3) tick();
    chk_reset_outputs("reset");
    $display("reset: occ=%0d free=%0d empty=%0b", bus_if.occupancy, bus_if.free_spaces, bus_if.empty);
    reset_n = 1'b1;
    repeat (2) tick();

    // Debounce latency: sensor_exit at edge 6, occupancy at edge 7.
    bus_if.raw_exit = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) chk("deb_sens_exit_e5", int'(bus_if.sensor_exit), 0);
      if (k == 6) begin
        chk("deb_sens_exit_e6", int'(bus_if.sensor_exit), 1);
        chk("deb_occ_e6", int'(bus_if.occupancy), 0);
      end
      if (k == 7) begin
        chk("deb_occ_e7", int'(bus_if.occupancy), 1);
        chk("deb_free_e7", int'(bus_if.free_spaces), 15);
        chk("deb_empty_e7", int'(bus_if.empty), 0);
      end
    end
    $display("debounce: sensor_exit=%0b occ=%0d", bus_if.sensor_exit, bus_if.occupancy);
    repeat (3) tick();
    bus_if.raw_exit = 1'b0;
    repeat (10) tick();

    // Three-sample glitch on raw_leave must be rejected.
    bus_if.raw_leave = 1'b1;
    repeat (3) tick();
    bus_if.raw_leave = 1'b0;
    repeat (12) tick();
    chk("glitch_occ", int'(bus_if.occupancy), 1);
    chk("glitch_unf", int'(bus_if.unf_err), 0);
    $display("glitch: occ=%0d unf=%0b", bus_if.occupancy, bus_if.unf_err);

    for (int i = 0; i < 2; i++) apply_vec(i);

    bus_if.clr_err = 1'b1;
    tick();
    bus_if.clr_err = 1'b0;
    chk("clr_unf", int'(bus_if.unf_err), 0);
    $display("clr_err: unf=%0b", bus_if.unf_err);

    for (int i = 2; i < 18; i++) apply_vec(i);

    bus_if.raw_entrance = 1'b1;
    repeat (10) tick();
    chk("full_sens_ent_masked", int'(bus_if.sensor_entrance), 0);
    chk("full_hex3", int'(bus_if.HEX_3), int'(EXP_HEX_FULL3));
    chk("full_hex4", int'(bus_if.HEX_4), int'(EXP_HEX_FULL4));
    $display("full: sensor_entrance=%0b hex3=%b hex4=%b", bus_if.sensor_entrance, bus_if.HEX_3, bus_if.HEX_4);

    apply_vec(18);

    // Free one space: full drops and sensor_entrance rises on the same edge.
    bus_if.raw_leave = 1'b1;
    found = 1'b0;
    prev_se = bus_if.sensor_entrance;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (bus_if.occupancy != 7'd16) found = 1'b1;
      else prev_se = bus_if.sensor_entrance;
    end
    chk("free_found", int'(found), 1);
    chk("free_prev_sens_ent", int'(prev_se), 0);
    chk("free_occ", int'(bus_if.occupancy), 15);
    chk("free_full", int'(bus_if.full), 0);
    chk("free_sens_ent", int'(bus_if.sensor_entrance), 1);
    $display("free: occ=%0d full=%0b sensor_entrance=%0b", bus_if.occupancy, bus_if.full, bus_if.sensor_entrance);
    repeat (5) tick();
    bus_if.raw_leave    = 1'b0;
    bus_if.raw_entrance = 1'b0;
    repeat (10) tick();

    for (int i = 19; i < 32; i++) apply_vec(i);

    chk("occ7_hex3", int'(bus_if.HEX_3), int'(EXP_HEX9_3));
    chk("occ7_hex4", int'(bus_if.HEX_4), int'(EXP_HEX9_4));
    $display("occ7: hex3=%b hex4=%b", bus_if.HEX_3, bus_if.HEX_4);

    // Asynchronous reset in the middle of a debounce.
    bus_if.raw_exit = 1'b1;
    repeat (4) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    bus_if.raw_exit = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (15) tick();
    chk("post_rst_occ", int'(bus_if.occupancy), 0);
    chk("post_rst_empty", int'(bus_if.empty), 1);
    chk("post_rst_free", int'(bus_if.free_spaces), 16);
    chk("post_rst_sens_exit", int'(bus_if.sensor_exit), 0);
    $display("post reset: occ=%0d empty=%0b", bus_if.occupancy, bus_if.empty);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
